// File: rtl/ram_task2_if.sv
// Request/completion handshake between the cache memory port and the block RAM.
// The shared block data bus is carried separately as a bidirectional net.
interface ram_task2_if #(parameter int ADDR_W = 10);
  logic [ADDR_W-1:0] address;
  logic              we;
  logic              mem_req;
  logic              mem_ready;

  modport master (output address, we, mem_req, input mem_ready);
  modport slave  (input address, we, mem_req, output mem_ready);
endinterface

// File: rtl/ram_task2.sv
// Block-organised backing RAM: one DATA_W block (two words) per request over a
// shared tri-state bus, req/ready handshake with a fixed LATENCY.
module ram_task2 #(
  parameter int ADDR_W  = 10,
  parameter int DATA_W  = 20,
  parameter int LATENCY = 1
) (
  input  logic             clk,
  input  logic             rst,
  ram_task2_if.slave       bus,
  inout  wire [DATA_W-1:0] data
);
  localparam int NBLK = 2 ** (ADDR_W - 1);
  localparam int WW   = DATA_W / 2;
  localparam int CW   = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  logic [ADDR_W-2:0] idx;
  logic [DATA_W-1:0] pat;
  logic [DATA_W-1:0] rd_word;
  logic [CW-1:0]     cnt;
  logic              rdy;
  logic              wr_en;

  // Each block stores its difference from the power-up pattern, so a cleared
  // array reads back as every word holding its own word address.
  logic [DATA_W-1:0] mem_d [NBLK];

  assign idx     = bus.address[ADDR_W-1:1];
  assign pat     = {WW'({idx, 1'b1}), WW'({idx, 1'b0})};
  assign rd_word = mem_d[idx] ^ pat;
  assign wr_en   = bus.mem_req & bus.we & rdy;

  assign bus.mem_ready = rdy;
  assign data = (bus.mem_req && !bus.we) ? rd_word : {DATA_W{1'bz}};

  always_ff @(posedge clk) begin
    if (wr_en) mem_d[idx] <= data ^ pat;
  end

  // Ready is a single-cycle pulse; the edge that ends it is never counted, so a
  // held request restarts counting on the following edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
      rdy <= 1'b0;
    end else if (rdy) begin
      cnt <= '0;
      rdy <= 1'b0;
    end else if (!bus.mem_req) begin
      cnt <= '0;
    end else if (cnt == CW'(LATENCY - 1)) begin
      cnt <= '0;
      rdy <= 1'b1;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end
endmodule

// File: tb/tb_ram_task2.sv
// Randomised and directed checks of ram_task2 at LATENCY=1 and LATENCY=3 against
// a transaction-level model of the array and handshake timing.
module tb_ram_task2;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        req   [2];
  logic        we    [2];
  logic [9:0]  addr  [2];
  logic [19:0] wdata [2];
  logic        drv   [2];

  int n_chk  = 0;
  int n_fail = 0;
  int pulses0 = 0;

  wire [19:0] data0;
  wire [19:0] data1;
  assign data0 = drv[0] ? wdata[0] : 20'bz;
  assign data1 = drv[1] ? wdata[1] : 20'bz;

  ram_task2_if ifa ();
  ram_task2_if ifb ();
  assign ifa.mem_req = req[0];
  assign ifa.we      = we[0];
  assign ifa.address = addr[0];
  assign ifb.mem_req = req[1];
  assign ifb.we      = we[1];
  assign ifb.address = addr[1];

  ram_task2 #(.ADDR_W(10), .DATA_W(20), .LATENCY(1)) u_dut0 (
    .clk(clk), .rst(rst), .bus(ifa), .data(data0));
  ram_task2 #(.ADDR_W(10), .DATA_W(20), .LATENCY(3)) u_dut1 (
    .clk(clk), .rst(rst), .bus(ifb), .data(data1));

  function automatic int lat(input int d);
    return (d == 0) ? 1 : 3;
  endfunction

  function automatic logic get_rdy(input int d);
    return (d == 0) ? ifa.mem_ready : ifb.mem_ready;
  endfunction

  function automatic logic [19:0] get_data(input int d);
    return (d == 0) ? data0 : data1;
  endfunction

  // Model: block contents plus number of counted request edges per DUT.
  logic [19:0] mm [2][512];
  int  age  [2];
  bit  rexp [2];

  initial begin
    for (int d = 0; d < 2; d++) begin
      for (int b = 0; b < 512; b++) mm[d][b] = {10'(2 * b + 1), 10'(2 * b)};
      age[d] = 0; rexp[d] = 1'b0;
      req[d] = 1'b0; we[d] = 1'b0; addr[d] = '0; wdata[d] = '0; drv[d] = 1'b0;
    end
  end

  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (rst) begin
        age[d] = 0; rexp[d] = 1'b0;
      end else if (rexp[d]) begin
        if (req[d] && we[d]) mm[d][addr[d][9:1]] = wdata[d];
        age[d] = 0; rexp[d] = 1'b0;
      end else if (!req[d]) begin
        age[d] = 0;
      end else begin
        age[d] = age[d] + 1;
        if (age[d] == lat(d)) begin age[d] = 0; rexp[d] = 1'b1; end
      end
    end
  end

  always @(posedge clk) begin
    #2;
    for (int d = 0; d < 2; d++) begin
      n_chk++;
      if (get_rdy(d) !== rexp[d]) begin
        n_fail++;
        $display("FAIL ready[%0d] t=%0t got %b want %b", d, $time, get_rdy(d), rexp[d]);
      end
      if (req[d] && !we[d]) begin
        n_chk++;
        if (get_data(d) !== mm[d][addr[d][9:1]]) begin
          n_fail++;
          $display("FAIL rdata[%0d] t=%0t addr %0d got %h want %h", d, $time, addr[d],
                   get_data(d), mm[d][addr[d][9:1]]);
        end
      end
    end
  end

  always @(posedge clk) begin
    #1;
    if (ifa.mem_ready) pulses0++;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s got %0d (%h) want %0d (%h)", nm, act, act, exp, exp);
    end
  endtask

  // One handshake; inputs held through the ready cycle so the write/capture edge sees them.
  task automatic xfer(input int d, input bit w, input logic [9:0] a, input logic [19:0] wd,
                      input bit hold, output logic [19:0] rd, output int cyc);
    @(negedge clk);
    addr[d] = a; we[d] = w; wdata[d] = wd; drv[d] = w; req[d] = 1'b1;
    cyc = 0; rd = '0;
    while (1) begin
      @(posedge clk); #1;
      cyc++;
      if (get_rdy(d)) begin rd = get_data(d); break; end
      if (cyc > 40) begin
        n_chk++; n_fail++;
        $display("FAIL timeout[%0d] addr %0d", d, a);
        break;
      end
    end
    @(posedge clk); #1;
    if (!hold) begin
      @(negedge clk);
      req[d] = 1'b0; drv[d] = 1'b0;
    end
  endtask

  task automatic abort(input int d, input logic [9:0] a, input logic [19:0] wd, input int k);
    @(negedge clk);
    addr[d] = a; we[d] = 1'b1; wdata[d] = wd; drv[d] = 1'b1; req[d] = 1'b1;
    repeat (k) @(posedge clk);
    @(negedge clk);
    req[d] = 1'b0; drv[d] = 1'b0;
  endtask

  task automatic rand_run(input int d, input int n);
    logic [19:0] rd;
    logic [9:0]  a;
    int cyc;
    for (int i = 0; i < n; i++) begin
      a = ($urandom_range(0, 1) == 1) ? 10'($urandom_range(80, 99)) : 10'($urandom_range(0, 1023));
      if (lat(d) > 1 && $urandom_range(0, 9) < 2)
        abort(d, a, 20'($urandom), $urandom_range(1, lat(d) - 1));
      else
        xfer(d, 1'($urandom_range(0, 1)), a, 20'($urandom), 1'b0, rd, cyc);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
  endtask

  initial begin
    logic [19:0] rd;
    int cyc;
    int p;
    repeat (2) @(posedge clk);
    #1 chk("reset_ready0", 32'(ifa.mem_ready), 32'd0);
    chk("reset_ready1", 32'(ifb.mem_ready), 32'd0);
    @(negedge clk) rst = 1'b0;

    xfer(0, 1'b0, 10'd50, '0, 1'b0, rd, cyc);
    chk("read50", 32'(rd), 32'({10'd51, 10'd50}));
    chk("read50_latency", 32'(cyc), 32'd1);
    xfer(0, 1'b0, 10'd51, '0, 1'b0, rd, cyc);
    chk("read51", 32'(rd), 32'({10'd51, 10'd50}));

    xfer(0, 1'b1, 10'd84, {10'd85, 10'd300}, 1'b0, rd, cyc);
    xfer(0, 1'b0, 10'd85, '0, 1'b0, rd, cyc);
    chk("read85_after_write", 32'(rd), 32'({10'd85, 10'd300}));
    xfer(0, 1'b0, 10'd86, '0, 1'b0, rd, cyc);
    chk("read86_neighbour", 32'(rd), 32'({10'd87, 10'd86}));

    p = pulses0;
    xfer(0, 1'b1, 10'd148, {10'd777, 10'd555}, 1'b1, rd, cyc);
    xfer(0, 1'b0, 10'd223, '0, 1'b0, rd, cyc);
    chk("b2b_read223", 32'(rd), 32'({10'd223, 10'd222}));
    chk("b2b_pulses", 32'(pulses0 - p), 32'd2);
    xfer(0, 1'b0, 10'd149, '0, 1'b0, rd, cyc);
    chk("b2b_read148", 32'(rd), 32'({10'd777, 10'd555}));

    abort(1, 10'd300, 20'hABCDE, 2);
    xfer(1, 1'b0, 10'd300, '0, 1'b0, rd, cyc);
    chk("abort_nowrite", 32'(rd), 32'({10'd301, 10'd300}));
    chk("lat3_latency", 32'(cyc), 32'd3);

    @(negedge clk);
    addr[1] = 10'd400; we[1] = 1'b1; wdata[1] = 20'h12345; drv[1] = 1'b1; req[1] = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1; req[1] = 1'b0; drv[1] = 1'b0;
    repeat (2) @(posedge clk);
    #1 chk("rst_mid_ready", 32'(ifb.mem_ready), 32'd0);
    @(negedge clk) rst = 1'b0;
    xfer(1, 1'b0, 10'd400, '0, 1'b0, rd, cyc);
    chk("rst_mid_nowrite", 32'(rd), 32'({10'd401, 10'd400}));

    fork
      rand_run(0, 150);
      rand_run(1, 120);
    join
    repeat (3) @(posedge clk);
    #3;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
